// File: rtl/dual_port_ram_banked.sv
// Banked two-port RAM with a post-reset clear engine, read valids and collision reporting.
// Optional macro DPRAM_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module dual_port_ram_banked #(
   parameter int unsigned ADDR_WIDTH      = 12,
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned BANK_ADDR_WIDTH = 11,
   parameter int unsigned WRITE_MODE      = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  ready,
   input  logic                  we1,
   input  logic                  we2,
   input  logic                  re1,
   input  logic                  re2,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [DATA_WIDTH-1:0] data1,
   input  logic [DATA_WIDTH-1:0] data2,
   output logic [DATA_WIDTH-1:0] out1,
   output logic [DATA_WIDTH-1:0] out2,
   output logic                  vld1,
   output logic                  vld2,
   output logic                  collision
);

   localparam int unsigned OffW     = (ADDR_WIDTH > BANK_ADDR_WIDTH) ? BANK_ADDR_WIDTH
                                                                     : ADDR_WIDTH;
   localparam int unsigned NumBanks = (ADDR_WIDTH > BANK_ADDR_WIDTH)
                                      ? (32'd1 << (ADDR_WIDTH - BANK_ADDR_WIDTH)) : 32'd1;
   localparam int unsigned BankW    = (NumBanks > 1) ? $clog2(NumBanks) : 1;
   localparam int unsigned Depth    = 32'd1 << OffW;

   typedef enum logic [0:0] {StClear, StReady} state_e;

   state_e                state_q, state_d;
   logic [OffW-1:0]       cnt_q, cnt_d;
   logic                  clear_en;

   logic [DATA_WIDTH-1:0] mem [NumBanks][Depth];

   logic [ADDR_WIDTH-1:0] addr_a [2];
   logic [DATA_WIDTH-1:0] data_a [2];
   logic [BankW-1:0]      bank_a [2];
   logic [OffW-1:0]       off_a  [2];
   logic [1:0]            wr_a, rd_a;
   logic                  same_addr;

   logic [DATA_WIDTH-1:0] bank_rd_d [2][NumBanks];
   logic [DATA_WIDTH-1:0] bank_rd_q [2][NumBanks];
   logic [BankW-1:0]      sel_q     [2];
   logic [1:0]            vld_q;
   logic                  coll_q;
   logic [DATA_WIDTH-1:0] mux_out   [2];

   function automatic logic [BankW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
      // With a single bank OffW equals ADDR_WIDTH, so the shift yields zero.
      return BankW'(a >> OffW);
   endfunction

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StClear: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = StReady;
         end
         StReady: state_d = StReady;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready    = 1'b0;
      clear_en = 1'b0;
      unique case (state_q)
         StClear: clear_en = 1'b1;
         StReady: ready    = 1'b1;
      endcase
   end

   assign addr_a[0] = addr1;
   assign addr_a[1] = addr2;
   assign data_a[0] = data1;
   assign data_a[1] = data2;
   assign bank_a[0] = bank_of(addr1);
   assign bank_a[1] = bank_of(addr2);
   assign off_a[0]  = OffW'(addr1);
   assign off_a[1]  = OffW'(addr2);

   assign same_addr = (addr1 == addr2);
   // Port 2 loses a same-address double write.
   assign wr_a[0]   = ready & we1;
   assign wr_a[1]   = ready & we2 & ~(we1 & same_addr);
   assign rd_a[0]   = ready & re1;
   assign rd_a[1]   = ready & re2;

   always_ff @(posedge clk) begin
      if (clear_en) begin
         for (int b = 0; b < NumBanks; b++) mem[b][cnt_q] <= '0;
      end else begin
         if (wr_a[0]) mem[bank_a[0]][off_a[0]] <= data_a[0];
         if (wr_a[1]) mem[bank_a[1]][off_a[1]] <= data_a[1];
      end
   end

   // Every bank reads its offset in parallel; write-through forwards the stored word.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         for (int b = 0; b < NumBanks; b++) begin
            bank_rd_d[p][b] = mem[b][off_a[p]];
            if (WRITE_MODE != 0 && bank_a[p] == BankW'(b)) begin
               if (wr_a[0] && addr_a[0] == addr_a[p]) begin
                  bank_rd_d[p][b] = data_a[0];
               end else if (wr_a[1] && addr_a[1] == addr_a[p]) begin
                  bank_rd_d[p][b] = data_a[1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NumBanks; b++) bank_rd_q[p][b] <= '0;
            sel_q[p] <= '0;
         end
         vld_q  <= '0;
         coll_q <= 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (rd_a[p]) begin
               for (int b = 0; b < NumBanks; b++) bank_rd_q[p][b] <= bank_rd_d[p][b];
               sel_q[p] <= bank_a[p];
            end
         end
         vld_q  <= rd_a;
         coll_q <= ready & we1 & we2 & same_addr;
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) mux_out[p] = bank_rd_q[p][sel_q[p]];
   end

   assign collision = coll_q;

`ifdef DPRAM_OUT_REG_EN
   logic [DATA_WIDTH-1:0] out_q [2];
   logic [1:0]            vld_out_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q[0]  <= '0;
         out_q[1]  <= '0;
         vld_out_q <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (vld_q[p]) out_q[p] <= mux_out[p];
         end
         vld_out_q <= vld_q;
      end
   end

   assign out1 = out_q[0];
   assign out2 = out_q[1];
   assign vld1 = vld_out_q[0];
   assign vld2 = vld_out_q[1];
`else
   assign out1 = mux_out[0];
   assign out2 = mux_out[1];
   assign vld1 = vld_q[0];
   assign vld2 = vld_q[1];
`endif

endmodule

// File: tb/tb_dual_port_ram_banked.sv
// Directed bench for dual_port_ram_banked: a read-first and a write-through instance share stimulus.
module tb_dual_port_ram_banked;

`ifdef DPRAM_OUT_REG_EN
   localparam int Lat = 2;
`else
   localparam int Lat = 1;
`endif

   logic        clk;
   logic        reset;
   logic        we1, we2, re1, re2;
   logic [11:0] addr1, addr2;
   logic [7:0]  data1, data2;

   logic        ready0, vld1_0, vld2_0, coll0;
   logic [7:0]  out1_0, out2_0;
   logic        ready1, vld1_1, vld2_1, coll1;
   logic [7:0]  out1_1, out2_1;

   int checks   = 0;
   int failures = 0;

   dual_port_ram_banked #(
      .ADDR_WIDTH(12), .DATA_WIDTH(8), .BANK_ADDR_WIDTH(11), .WRITE_MODE(0)
   ) dut0 (
      .clk(clk), .reset(reset), .ready(ready0),
      .we1(we1), .we2(we2), .re1(re1), .re2(re2),
      .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
      .out1(out1_0), .out2(out2_0), .vld1(vld1_0), .vld2(vld2_0), .collision(coll0)
   );

   dual_port_ram_banked #(
      .ADDR_WIDTH(12), .DATA_WIDTH(8), .BANK_ADDR_WIDTH(11), .WRITE_MODE(1)
   ) dut1 (
      .clk(clk), .reset(reset), .ready(ready1),
      .we1(we1), .we2(we2), .re1(re1), .re2(re2),
      .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
      .out1(out1_1), .out2(out2_1), .vld1(vld1_1), .vld2(vld2_1), .collision(coll1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct packed {
      logic       we1;
      logic       re1;
      logic [11:0] a1;
      logic [7:0] d1;
      logic       we2;
      logic       re2;
      logic [11:0] a2;
      logic [7:0] d2;
      logic       coll;
      logic [7:0] o1;   // read-first instance
      logic [7:0] o2;
      logic [7:0] o1w;  // write-through instance
      logic [7:0] o2w;
   } vec_t;

   localparam int NumVecs = 21;
   vec_t vecs [NumVecs];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we1 = 1'b0; we2 = 1'b0; re1 = 1'b0; re2 = 1'b0;
      addr1 = '0; addr2 = '0; data1 = '0; data2 = '0;
   endtask

   task automatic rd(input logic [11:0] a1, input logic [11:0] a2);
      re1 = 1'b1; re2 = 1'b1; addr1 = a1; addr2 = a2;
      step();
      idle();
      for (int l = 1; l < Lat; l++) step();
   endtask

   initial begin
      int n;
      int bad;
      int j;

      //          we1  re1  a1       d1     we2  re2  a2       d2     coll  o1     o2     o1w    o2w
      vecs[0]  = '{1'b0,1'b1,12'h000,8'h00, 1'b0,1'b1,12'h7FF,8'h00, 1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[1]  = '{1'b0,1'b1,12'h800,8'h00, 1'b0,1'b1,12'hFFF,8'h00, 1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[2]  = '{1'b1,1'b0,12'h801,8'hA5, 1'b0,1'b0,12'h000,8'h00, 1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[3]  = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b1,12'h801,8'h00, 1'b0, 8'h00,8'hA5,8'h00,8'hA5};
      vecs[4]  = '{1'b0,1'b1,12'h001,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0, 8'h00,8'hA5,8'h00,8'hA5};
      vecs[5]  = '{1'b1,1'b0,12'h010,8'h11, 1'b1,1'b0,12'h010,8'h22, 1'b1, 8'h00,8'hA5,8'h00,8'hA5};
      vecs[6]  = '{1'b0,1'b1,12'h010,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0, 8'h11,8'hA5,8'h11,8'hA5};
      vecs[7]  = '{1'b1,1'b0,12'h020,8'h33, 1'b0,1'b0,12'h000,8'h00, 1'b0, 8'h11,8'hA5,8'h11,8'hA5};
      vecs[8]  = '{1'b1,1'b0,12'h020,8'h5A, 1'b0,1'b1,12'h020,8'h00, 1'b0, 8'h11,8'h33,8'h11,8'h5A};
      vecs[9]  = '{1'b0,1'b1,12'h020,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0, 8'h5A,8'h33,8'h5A,8'h5A};
      vecs[10] = '{1'b1,1'b0,12'h7FF,8'hC3, 1'b1,1'b0,12'h800,8'h3C, 1'b0, 8'h5A,8'h33,8'h5A,8'h5A};
      vecs[11] = '{1'b0,1'b1,12'h7FF,8'h00, 1'b0,1'b1,12'h800,8'h00, 1'b0, 8'hC3,8'h3C,8'hC3,8'h3C};
      vecs[12] = '{1'b0,1'b1,12'h800,8'h00, 1'b0,1'b1,12'h7FF,8'h00, 1'b0, 8'h3C,8'hC3,8'h3C,8'hC3};
      vecs[13] = '{1'b0,1'b1,12'h0FF,8'h00, 1'b1,1'b0,12'h0FF,8'h77, 1'b0, 8'h00,8'hC3,8'h77,8'hC3};
      vecs[14] = '{1'b0,1'b1,12'h0FF,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0, 8'h77,8'hC3,8'h77,8'hC3};
      vecs[15] = '{1'b1,1'b0,12'h123,8'h01, 1'b1,1'b0,12'h124,8'h02, 1'b0, 8'h77,8'hC3,8'h77,8'hC3};
      vecs[16] = '{1'b0,1'b1,12'h124,8'h00, 1'b0,1'b1,12'h123,8'h00, 1'b0, 8'h02,8'h01,8'h02,8'h01};
      vecs[17] = '{1'b1,1'b0,12'h300,8'hAA, 1'b1,1'b1,12'h300,8'hBB, 1'b1, 8'h02,8'h00,8'h02,8'hAA};
      vecs[18] = '{1'b0,1'b1,12'h300,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0, 8'hAA,8'h00,8'hAA,8'hAA};
      vecs[19] = '{1'b0,1'b1,12'hFFF,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0, 8'h00,8'h00,8'h00,8'hAA};
      vecs[20] = '{1'b0,1'b1,12'h7FF,8'h00, 1'b0,1'b1,12'h801,8'h00, 1'b0, 8'hC3,8'hA5,8'hC3,8'hA5};

      // Reset values and clear duration.
      idle();
      reset = 1'b1;
      step();
      step();
      chk("rst_ready", ready0, 0);
      chk("rst_out1", out1_0, 0);
      chk("rst_out2", out2_0, 0);
      chk("rst_vld1", vld1_0, 0);
      chk("rst_vld2", vld2_0, 0);
      chk("rst_coll", coll0, 0);
      reset = 1'b0;
      n = 0;
      while (!ready0 && n < 3000) begin
         step();
         n++;
      end
      chk("clear_cycles", n, 2048);

      for (int i = 0; i < NumVecs; i++) begin
         we1 = vecs[i].we1; re1 = vecs[i].re1; addr1 = vecs[i].a1; data1 = vecs[i].d1;
         we2 = vecs[i].we2; re2 = vecs[i].re2; addr2 = vecs[i].a2; data2 = vecs[i].d2;
         step();
         idle();
         chk($sformatf("v%0d_coll", i), coll0, vecs[i].coll);
         for (int l = 1; l < Lat; l++) step();
         chk($sformatf("v%0d_vld1", i), vld1_0, vecs[i].re1);
         chk($sformatf("v%0d_vld2", i), vld2_0, vecs[i].re2);
         chk($sformatf("v%0d_out1", i), out1_0, vecs[i].o1);
         chk($sformatf("v%0d_out2", i), out2_0, vecs[i].o2);
         chk($sformatf("v%0d_wt_out1", i), out1_1, vecs[i].o1w);
         chk($sformatf("v%0d_wt_out2", i), out2_1, vecs[i].o2w);
      end

      // Asynchronous reset mid-traffic, then reset again at clear cycle 100.
      reset = 1'b1;
      #1;
      chk("async_rst_ready", ready0, 0);
      chk("async_rst_out1", out1_0, 0);
      chk("async_rst_out2", out2_0, 0);
      chk("async_rst_wt_out2", out2_1, 0);
      step();
      step();
      reset = 1'b0;
      we1 = 1'b1; we2 = 1'b1; re1 = 1'b1; re2 = 1'b1;
      addr1 = 12'h801; addr2 = 12'h801; data1 = 8'hFF; data2 = 8'hEE;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (vld1_0 || vld2_0 || coll0 || ready0) bad++;
      end
      reset = 1'b1;
      #1;
      chk("reclear_rst_ready", ready0, 0);
      step();
      reset = 1'b0;
      n = 0;
      while (!ready0 && n < 3000) begin
         step();
         n++;
         if (vld1_0 || vld2_0 || coll0) bad++;
      end
      idle();
      chk("reclear_cycles", n, 2048);
      chk("clear_quiet", bad, 0);

      rd(12'h801, 12'h7FF);
      chk("cleared_801_vld", vld1_0, 1);
      chk("cleared_801", out1_0, 0);
      chk("cleared_7ff", out2_0, 0);
      rd(12'h010, 12'h300);
      chk("cleared_010", out1_0, 0);
      chk("cleared_300", out2_0, 0);

      // Back-to-back alternating reads across the bank boundary.
      we1 = 1'b1; addr1 = 12'h7FF; data1 = 8'hC3;
      we2 = 1'b1; addr2 = 12'h800; data2 = 8'h3C;
      step();
      idle();
      for (int k = 0; k < 8 + Lat - 1; k++) begin
         if (k < 8) begin
            re1 = 1'b1; re2 = 1'b1;
            addr1 = (k % 2 == 1) ? 12'h800 : 12'h7FF;
            addr2 = (k % 2 == 1) ? 12'h7FF : 12'h800;
         end else begin
            idle();
         end
         step();
         if (k >= Lat - 1) begin
            j = k - Lat + 1;
            chk($sformatf("b2b%0d_vld1", j), vld1_0, 1);
            chk($sformatf("b2b%0d_vld2", j), vld2_0, 1);
            chk($sformatf("b2b%0d_out1", j), out1_0, (j % 2 == 1) ? 8'h3C : 8'hC3);
            chk($sformatf("b2b%0d_out2", j), out2_0, (j % 2 == 1) ? 8'hC3 : 8'h3C);
         end
      end
      idle();
      step();
      chk("b2b_vld_end", vld1_0, 0);
      chk("b2b_hold_out1", out1_0, 8'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
